// File: rtl/uart_pb_pkg.sv
// Shared defaults and the index-width helper for the fractional UART baud generator.
package uart_pb_pkg;

   localparam int PB_DIV_WIDTH  = 16;
   localparam int PB_FRAC_BITS  = 4;
   localparam int PB_OVERSAMPLE = 16;

   function automatic int pb_log2(input int value);
      return $clog2(value);
   endfunction

   localparam int PB_IDX_WIDTH = pb_log2(PB_OVERSAMPLE);

endpackage

// File: rtl/uart_frac_accum.sv
// Fractional phase accumulator: a carry at a sample-period wrap stretches the next period by one clk.
module uart_frac_accum
   import uart_pb_pkg::*;
#(
   parameter int FRAC_BITS = PB_FRAC_BITS
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 step,
   input  logic [FRAC_BITS-1:0] frac,
   output logic                 extend
);

   logic [FRAC_BITS-1:0] acc_q;
   logic [FRAC_BITS:0]   sum;

   assign sum = {1'b0, acc_q} + {1'b0, frac};

   // extend only changes at a wrap, so it covers exactly one following period
   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         acc_q  <= '0;
         extend <= 1'b0;
      end else if (step) begin
         acc_q  <= sum[FRAC_BITS-1:0];
         extend <= sum[FRAC_BITS];
      end
   end

endmodule

// File: rtl/uart_baud_gen_frac.sv
// Fractional-N UART baud generator producing oversample, bit-centre and bit-end ticks.
module uart_baud_gen_frac
   import uart_pb_pkg::*;
#(
   parameter int DIV_WIDTH  = PB_DIV_WIDTH,
   parameter int FRAC_BITS  = PB_FRAC_BITS,
   parameter int OVERSAMPLE = PB_OVERSAMPLE
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             enable,
   input  logic                             restart,
   input  logic [DIV_WIDTH-1:0]             clock_divide,
   input  logic [FRAC_BITS-1:0]             frac_divide,
   output logic                             sample_tick,
   output logic                             mid_tick,
   output logic                             baud_tick,
   output logic [pb_log2(OVERSAMPLE)-1:0]   sample_index
);

   localparam int IDX_W = pb_log2(OVERSAMPLE);
   localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(OVERSAMPLE - 1);
   localparam logic [IDX_W-1:0] IDX_PRE_MID = IDX_W'(OVERSAMPLE / 2 - 1);
   localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);
   localparam logic [DIV_WIDTH:0] CNT_ONE   = (DIV_WIDTH + 1)'(1);

   logic [DIV_WIDTH-1:0] div_q;
   logic [FRAC_BITS-1:0] frac_q;
   logic [DIV_WIDTH:0]   cnt_q;
   logic [DIV_WIDTH:0]   limit;
   logic                 extend;
   logic                 wrap;

   // one extra bit so div_q = all-ones plus extend cannot overflow
   assign limit = {1'b0, div_q} + {{DIV_WIDTH{1'b0}}, extend};
   assign wrap  = enable && !restart && (cnt_q == limit);

   uart_frac_accum #(
      .FRAC_BITS (FRAC_BITS)
   ) u_frac_accum (
      .clk    (clk),
      .reset  (reset),
      .clear  (restart),
      .step   (wrap),
      .frac   (frac_q),
      .extend (extend)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q        <= '0;
         sample_index <= '0;
         sample_tick  <= 1'b0;
         mid_tick     <= 1'b0;
         baud_tick    <= 1'b0;
         div_q        <= clock_divide;
         frac_q       <= frac_divide;
      end else if (restart) begin
         cnt_q        <= '0;
         sample_index <= '0;
         sample_tick  <= 1'b0;
         mid_tick     <= 1'b0;
         baud_tick    <= 1'b0;
         div_q        <= clock_divide;
         frac_q       <= frac_divide;
      end else if (!enable) begin
         sample_tick  <= 1'b0;
         mid_tick     <= 1'b0;
         baud_tick    <= 1'b0;
      end else if (wrap) begin
         // divisor changes are only picked up here, at a period boundary
         cnt_q        <= '0;
         sample_tick  <= 1'b1;
         mid_tick     <= (sample_index == IDX_PRE_MID);
         baud_tick    <= (sample_index == IDX_LAST);
         sample_index <= (sample_index == IDX_LAST) ? '0 : sample_index + IDX_ONE;
         div_q        <= clock_divide;
         frac_q       <= frac_divide;
      end else begin
         cnt_q        <= cnt_q + CNT_ONE;
         sample_tick  <= 1'b0;
         mid_tick     <= 1'b0;
         baud_tick    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Scoreboard bench for uart_baud_gen_frac: expected tick times are queued per scenario and popped as ticks appear.
module tb_uart_baud_gen_frac;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        restart;
   logic [15:0] clock_divide;
   logic [3:0]  frac_divide;
   logic        sample_tick;
   logic        mid_tick;
   logic        baud_tick;
   logic [3:0]  sample_index;

   typedef struct {
      int       t;
      logic     mid;
      logic     baud;
      logic [3:0] idx;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   uart_baud_gen_frac #(
      .DIV_WIDTH  (16),
      .FRAC_BITS  (4),
      .OVERSAMPLE (16)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .restart      (restart),
      .clock_divide (clock_divide),
      .frac_divide  (frac_divide),
      .sample_tick  (sample_tick),
      .mid_tick     (mid_tick),
      .baud_tick    (baud_tick),
      .sample_index (sample_index)
   );

   // k-th sample tick since the phase origin: index k mod 16, centre at 8, bit end at 0
   function automatic void push_exp(input int t, input int k);
      exp_t e;
      e.t    = t;
      e.idx  = 4'(k % 16);
      e.mid  = ((k % 16) == 8);
      e.baud = ((k % 16) == 0);
      exp_q.push_back(e);
   endfunction

   task automatic apply_restart();
      restart = 1'b1;
      @(posedge clk); #1;
      restart = 1'b0;
   endtask

   task automatic test_reset();
      exp_t e;
      reset = 1'b0; enable = 1'b1; restart = 1'b0;
      clock_divide = 16'd3; frac_divide = 4'd0;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if ({sample_tick, mid_tick, baud_tick, sample_index} !== 7'd0) begin
         n_bad++;
         $display("FAIL reset_state: got %b, expected 0000000", {sample_tick, mid_tick, baud_tick, sample_index});
      end
      reset = 1'b1;
      for (int k = 1; k <= 5; k++) push_exp(4 * k, k);
      for (int t = 1; t <= 21; t++) begin
         @(posedge clk); #1;
         if (sample_tick) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_bad++; $display("FAIL reset_release: unexpected tick at t=%0d", t);
            end else begin
               e = exp_q.pop_front();
               if (t != e.t || mid_tick !== e.mid || baud_tick !== e.baud || sample_index !== e.idx) begin
                  n_bad++;
                  $display("FAIL reset_release: t=%0d mid=%b baud=%b idx=%0d, expected t=%0d mid=%b baud=%b idx=%0d",
                           t, mid_tick, baud_tick, sample_index, e.t, e.mid, e.baud, e.idx);
               end
            end
         end else if (mid_tick || baud_tick) begin
            n_vec++; n_bad++; $display("FAIL reset_release: stray mid/baud tick at t=%0d", t);
         end
      end
      n_vec++;
      if (exp_q.size() != 0) begin
         n_bad++; $display("FAIL reset_release: %0d ticks missing, first due t=%0d", exp_q.size(), exp_q[0].t);
         exp_q.delete();
      end
   endtask

   task automatic test_integer_divide();
      exp_t e;
      clock_divide = 16'd3; frac_divide = 4'd0;
      apply_restart();
      for (int k = 1; k <= 35; k++) push_exp(4 * k, k);
      for (int t = 1; t <= 142; t++) begin
         @(posedge clk); #1;
         if (sample_tick) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_bad++; $display("FAIL integer_div: unexpected tick at t=%0d", t);
            end else begin
               e = exp_q.pop_front();
               if (t != e.t || mid_tick !== e.mid || baud_tick !== e.baud || sample_index !== e.idx) begin
                  n_bad++;
                  $display("FAIL integer_div: t=%0d mid=%b baud=%b idx=%0d, expected t=%0d mid=%b baud=%b idx=%0d",
                           t, mid_tick, baud_tick, sample_index, e.t, e.mid, e.baud, e.idx);
               end
            end
         end else if (mid_tick || baud_tick) begin
            n_vec++; n_bad++; $display("FAIL integer_div: stray mid/baud tick at t=%0d", t);
         end
      end
      n_vec++;
      if (exp_q.size() != 0) begin
         n_bad++; $display("FAIL integer_div: %0d ticks missing, first due t=%0d", exp_q.size(), exp_q[0].t);
         exp_q.delete();
      end
   endtask

   task automatic test_fractional();
      exp_t e;
      int   obs[$];
      int   tt;
      int   k;
      clock_divide = 16'd3; frac_divide = 4'd8;
      apply_restart();
      // accumulator starts at 0, so the first two periods are 4, then 5,4,5,...
      tt = 0; k = 1;
      while (1) begin
         tt += (k == 1 || (k % 2) == 0) ? 4 : 5;
         if (tt > 80) break;
         push_exp(tt, k);
         k++;
      end
      for (int t = 1; t <= 82; t++) begin
         @(posedge clk); #1;
         if (sample_tick) begin
            obs.push_back(t);
            n_vec++;
            if (exp_q.size() == 0) begin
               n_bad++; $display("FAIL frac_div: unexpected tick at t=%0d", t);
            end else begin
               e = exp_q.pop_front();
               if (t != e.t || mid_tick !== e.mid || baud_tick !== e.baud || sample_index !== e.idx) begin
                  n_bad++;
                  $display("FAIL frac_div: t=%0d mid=%b baud=%b idx=%0d, expected t=%0d mid=%b baud=%b idx=%0d",
                           t, mid_tick, baud_tick, sample_index, e.t, e.mid, e.baud, e.idx);
               end
            end
         end else if (mid_tick || baud_tick) begin
            n_vec++; n_bad++; $display("FAIL frac_div: stray mid/baud tick at t=%0d", t);
         end
      end
      n_vec++;
      if (exp_q.size() != 0) begin
         n_bad++; $display("FAIL frac_div: %0d ticks missing, first due t=%0d", exp_q.size(), exp_q[0].t);
         exp_q.delete();
      end
      n_vec++;
      if (obs.size() < 17) begin
         n_bad++; $display("FAIL frac_span: only %0d ticks seen, need 17", obs.size());
      end else if (obs[16] - obs[0] != 72) begin
         n_bad++; $display("FAIL frac_span: 16 periods took %0d cycles, expected 72", obs[16] - obs[0]);
      end
      frac_divide = 4'd0;
   endtask

   task automatic test_enable_hold();
      exp_t e;
      clock_divide = 16'd0; frac_divide = 4'd0; enable = 1'b1;
      apply_restart();
      for (int k = 1; k <= 6; k++) push_exp(k, k);
      for (int k = 7; k <= 11; k++) push_exp(k + 5, k);
      for (int t = 1; t <= 16; t++) begin
         @(posedge clk); #1;
         if (sample_tick) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_bad++; $display("FAIL enable_hold: unexpected tick at t=%0d", t);
            end else begin
               e = exp_q.pop_front();
               if (t != e.t || mid_tick !== e.mid || baud_tick !== e.baud || sample_index !== e.idx) begin
                  n_bad++;
                  $display("FAIL enable_hold: t=%0d mid=%b baud=%b idx=%0d, expected t=%0d mid=%b baud=%b idx=%0d",
                           t, mid_tick, baud_tick, sample_index, e.t, e.mid, e.baud, e.idx);
               end
            end
         end else if (mid_tick || baud_tick) begin
            n_vec++; n_bad++; $display("FAIL enable_hold: stray mid/baud tick at t=%0d", t);
         end
         if (t >= 7 && t <= 11) begin
            n_vec++;
            if (sample_index !== 4'd6) begin
               n_bad++; $display("FAIL enable_hold_idx: t=%0d idx=%0d, expected 6", t, sample_index);
            end
         end
         if (t == 6)  enable = 1'b0;
         if (t == 11) enable = 1'b1;
      end
      n_vec++;
      if (exp_q.size() != 0) begin
         n_bad++; $display("FAIL enable_hold: %0d ticks missing, first due t=%0d", exp_q.size(), exp_q[0].t);
         exp_q.delete();
      end
   endtask

   task automatic test_restart();
      exp_t e;
      clock_divide = 16'd3; frac_divide = 4'd0; enable = 1'b1;
      apply_restart();
      for (int k = 1; k <= 9; k++) push_exp(4 * k, k);
      for (int j = 1; j <= 9; j++) push_exp(40 + 4 * j, j);
      for (int t = 1; t <= 78; t++) begin
         @(posedge clk); #1;
         if (sample_tick) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_bad++; $display("FAIL restart: unexpected tick at t=%0d", t);
            end else begin
               e = exp_q.pop_front();
               if (t != e.t || mid_tick !== e.mid || baud_tick !== e.baud || sample_index !== e.idx) begin
                  n_bad++;
                  $display("FAIL restart: t=%0d mid=%b baud=%b idx=%0d, expected t=%0d mid=%b baud=%b idx=%0d",
                           t, mid_tick, baud_tick, sample_index, e.t, e.mid, e.baud, e.idx);
               end
            end
         end else if (mid_tick || baud_tick) begin
            n_vec++; n_bad++; $display("FAIL restart: stray mid/baud tick at t=%0d", t);
         end
         if (t == 40) begin
            n_vec++;
            if ({sample_tick, mid_tick, baud_tick, sample_index} !== 7'd0) begin
               n_bad++;
               $display("FAIL restart_suppress: got %b, expected 0000000", {sample_tick, mid_tick, baud_tick, sample_index});
            end
            restart = 1'b0;
         end
         // lands on the edge where the idx 9 -> 10 wrap would have happened
         if (t == 39) restart = 1'b1;
      end
      n_vec++;
      if (exp_q.size() != 0) begin
         n_bad++; $display("FAIL restart: %0d ticks missing, first due t=%0d", exp_q.size(), exp_q[0].t);
         exp_q.delete();
      end
   endtask

   task automatic test_divisor_change();
      exp_t e;
      clock_divide = 16'd3; frac_divide = 4'd0; enable = 1'b1;
      apply_restart();
      push_exp(4, 1); push_exp(8, 2); push_exp(16, 3); push_exp(24, 4); push_exp(32, 5);
      for (int t = 1; t <= 35; t++) begin
         @(posedge clk); #1;
         if (sample_tick) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_bad++; $display("FAIL div_change: unexpected tick at t=%0d", t);
            end else begin
               e = exp_q.pop_front();
               if (t != e.t || mid_tick !== e.mid || baud_tick !== e.baud || sample_index !== e.idx) begin
                  n_bad++;
                  $display("FAIL div_change: t=%0d mid=%b baud=%b idx=%0d, expected t=%0d mid=%b baud=%b idx=%0d",
                           t, mid_tick, baud_tick, sample_index, e.t, e.mid, e.baud, e.idx);
               end
            end
         end else if (mid_tick || baud_tick) begin
            n_vec++; n_bad++; $display("FAIL div_change: stray mid/baud tick at t=%0d", t);
         end
         if (t == 6) clock_divide = 16'd7;
      end
      n_vec++;
      if (exp_q.size() != 0) begin
         n_bad++; $display("FAIL div_change: %0d ticks missing, first due t=%0d", exp_q.size(), exp_q[0].t);
         exp_q.delete();
      end
      clock_divide = 16'd3;
   endtask

   task automatic test_reset_mid_bit();
      exp_t e;
      clock_divide = 16'd3; frac_divide = 4'd0; enable = 1'b1;
      apply_restart();
      for (int k = 1; k <= 9; k++) push_exp(4 * k, k);
      push_exp(47, 1); push_exp(53, 2);
      for (int t = 1; t <= 55; t++) begin
         @(posedge clk); #1;
         if (sample_tick) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_bad++; $display("FAIL reset_mid: unexpected tick at t=%0d", t);
            end else begin
               e = exp_q.pop_front();
               if (t != e.t || mid_tick !== e.mid || baud_tick !== e.baud || sample_index !== e.idx) begin
                  n_bad++;
                  $display("FAIL reset_mid: t=%0d mid=%b baud=%b idx=%0d, expected t=%0d mid=%b baud=%b idx=%0d",
                           t, mid_tick, baud_tick, sample_index, e.t, e.mid, e.baud, e.idx);
               end
            end
         end else if (mid_tick || baud_tick) begin
            n_vec++; n_bad++; $display("FAIL reset_mid: stray mid/baud tick at t=%0d", t);
         end
         if (t == 40) begin
            n_vec++;
            if ({sample_tick, mid_tick, baud_tick, sample_index} !== 7'd0) begin
               n_bad++;
               $display("FAIL reset_mid_clear: got %b, expected 0000000", {sample_tick, mid_tick, baud_tick, sample_index});
            end
         end
         // new divisor during reset must be the one used after release (period 6)
         if (t == 39) begin reset = 1'b0; clock_divide = 16'd5; end
         if (t == 41) reset = 1'b1;
      end
      n_vec++;
      if (exp_q.size() != 0) begin
         n_bad++; $display("FAIL reset_mid: %0d ticks missing, first due t=%0d", exp_q.size(), exp_q[0].t);
         exp_q.delete();
      end
   endtask

   initial begin
      test_reset();
      test_integer_divide();
      test_fractional();
      test_enable_hold();
      test_restart();
      test_divisor_change();
      test_reset_mid_bit();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
